// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Instruction-fetch front end. Owns the fetch PC, issues sequential reads to
//   instruction memory under a credit limit, carries each issued PC through a
//   MEM_LAT-deep valid/PC pipeline, writes returned words with their PC into a
//   DEPTH-entry FIFO, and presents the FIFO head to decode over valid/ready.
//   A redirect flushes the FIFO and every in-flight read, then restarts fetch
//   at the word-aligned target.
// Ports
//   CLK, RST           clock (rising edge) / synchronous active-high reset
//   mem_rd_en          read request this cycle
//   mem_raddr          read address (same as fetch_pc)
//   mem_rdata          read data, valid MEM_LAT cycles after the request edge
//   redirect_valid/pc  load new PC, flush queue and in-flight reads
//   out_valid/ready    head handshake to decode
//   out_instr/out_pc   head instruction and its PC
//   fetch_pc           next PC to be requested
//   occupancy          entries currently held in the queue
module instr_fetch_queue #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      ILEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MEM_LAT  = 1,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     mem_rd_en,
  output logic [XLEN-1:0]          mem_raddr,
  input  logic [ILEN-1:0]          mem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0]    r_pc;
  logic [MEM_LAT-1:0] r_pipe_v;
  logic [XLEN-1:0]    r_pipe_pc [MEM_LAT];
  logic [ILEN-1:0]    r_q_instr [DEPTH];
  logic [XLEN-1:0]    r_q_pc    [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic [SW-1:0]      w_inflight;
  logic               w_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_out_valid;
  logic               w_pop;
  logic [XLEN-1:0]    w_redir_pc;
  logic [1:0]         w_unused_lsbs;

  // Requests already issued but not yet returned.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + SW'(r_pipe_v[i]);
    end
  end

  // Queue entries plus outstanding reads never exceed DEPTH, so a return
  // always finds a free slot.
  assign w_credit    = (SW'(r_count) + w_inflight) < SW'(DEPTH);
  assign w_issue     = !RST && !redirect_valid && w_credit;
  assign w_push      = r_pipe_v[MEM_LAT-1] && !RST && !redirect_valid;
  assign w_out_valid = (r_count != '0) && !redirect_valid && !RST;
  assign w_pop       = w_out_valid && out_ready;

  assign w_redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_lsbs = redirect_pc[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc     <= RESET_PC;
      r_pipe_v <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        r_pipe_pc[i] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over issue, return and pop; late returns are dropped
      // by clearing the pipeline valid bits.
      r_pc     <= w_redir_pc;
      r_pipe_v <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + XLEN'(PC_STEP);
      end

      r_pipe_v[0]  <= w_issue;
      r_pipe_pc[0] <= r_pc;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        r_pipe_v[i]  <= r_pipe_v[i-1];
        r_pipe_pc[i] <= r_pipe_pc[i-1];
      end

      if (w_push) begin
        r_q_instr[r_wr_ptr] <= mem_rdata;
        r_q_pc[r_wr_ptr]    <= r_pipe_pc[MEM_LAT-1];
        r_wr_ptr            <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_rd_en = w_issue;
  assign mem_raddr = r_pc;
  assign fetch_pc  = r_pc;
  assign out_valid = w_out_valid;
  assign out_instr = r_q_instr[r_rd_ptr];
  assign out_pc    = r_q_pc[r_rd_ptr];
  assign occupancy = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Two instances: A (DEPTH=4, MEM_LAT=1, RESET_PC=0) and B (DEPTH=4,
//   MEM_LAT=3, RESET_PC=...FFF8). Each has a memory model returning addr[31:0]
//   MEM_LAT cycles after the request edge. Expected PCs are queued per scenario
//   and popped on every accepted output beat.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  // Instance A
  logic        a_rst = 1'b1, a_rd_en, a_redir = 1'b0, a_ovalid, a_oready = 1'b0;
  logic [63:0] a_raddr, a_redir_pc = '0, a_opc, a_fpc;
  logic [31:0] a_rdata, a_oinstr;
  logic [2:0]  a_occ;

  instr_fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .MEM_LAT(1),
    .RESET_PC(64'h0), .PC_STEP(4)
  ) u_a (
    .CLK(clk), .RST(a_rst),
    .mem_rd_en(a_rd_en), .mem_raddr(a_raddr), .mem_rdata(a_rdata),
    .redirect_valid(a_redir), .redirect_pc(a_redir_pc),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .out_instr(a_oinstr), .out_pc(a_opc),
    .fetch_pc(a_fpc), .occupancy(a_occ)
  );

  logic [63:0] a_m1;
  always @(posedge clk) a_m1 <= a_raddr;
  assign a_rdata = a_m1[31:0];

  // Instance B
  logic        b_rst = 1'b1, b_rd_en, b_redir = 1'b0, b_ovalid, b_oready = 1'b0;
  logic [63:0] b_raddr, b_redir_pc = '0, b_opc, b_fpc;
  logic [31:0] b_rdata, b_oinstr;
  logic [2:0]  b_occ;

  instr_fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .MEM_LAT(3),
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .PC_STEP(4)
  ) u_b (
    .CLK(clk), .RST(b_rst),
    .mem_rd_en(b_rd_en), .mem_raddr(b_raddr), .mem_rdata(b_rdata),
    .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .out_instr(b_oinstr), .out_pc(b_opc),
    .fetch_pc(b_fpc), .occupancy(b_occ)
  );

  logic [63:0] b_m [3];
  always @(posedge clk) begin
    b_m[0] <= b_raddr;
    b_m[1] <= b_m[0];
    b_m[2] <= b_m[1];
  end
  assign b_rdata = b_m[2][31:0];

  // Reset helpers: return at the sample point of the first cycle out of reset.
  task automatic reset_a(input logic rdy);
    @(negedge clk); a_rst = 1'b1; a_redir = 1'b0; a_oready = rdy;
    repeat (2) @(negedge clk);
    a_rst = 1'b0; #1;
  endtask

  task automatic reset_b(input logic rdy);
    @(negedge clk); b_rst = 1'b1; b_redir = 1'b0; b_oready = rdy;
    repeat (2) @(negedge clk);
    b_rst = 1'b0; #1;
  endtask

  task automatic test_reset;
    @(negedge clk); a_rst = 1'b1; a_oready = 1'b1; a_redir = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (a_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b expected 0", a_rd_en); end
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", a_ovalid); end
    @(negedge clk); a_rst = 1'b0; #1;
    n_cmp++; if (a_fpc !== 64'h0) begin n_err++; $display("FAIL rst_fetch_pc: got %h expected 0", a_fpc); end
    n_cmp++; if (a_raddr !== 64'h0) begin n_err++; $display("FAIL rst_raddr: got %h expected 0", a_raddr); end
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL rst_occ: got %0d expected 0", a_occ); end
    n_cmp++; if (a_oinstr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr: got %h expected 0", a_oinstr); end
    n_cmp++; if (a_opc !== 64'h0) begin n_err++; $display("FAIL rst_out_pc: got %h expected 0", a_opc); end
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL rst_valid_after: got %b expected 0", a_ovalid); end
  endtask

  // Scenario 1: streaming from reset, latency and one-per-cycle throughput.
  task automatic test_stream;
    int first;
    logic [63:0] e;
    reset_a(1'b1);
    n_cmp++; if (a_rd_en !== 1'b1) begin n_err++; $display("FAIL stream_first_req: got %b expected 1", a_rd_en); end
    for (int i = 0; i < 8; i++) exp_a.push_back(64'(i * 4));
    first = -1;
    for (int cyc = 0; cyc < 40 && exp_a.size() != 0; cyc++) begin
      if (cyc != 0) begin @(negedge clk); #1; end
      if (first >= 0) begin
        n_cmp++; if (a_ovalid !== 1'b1) begin n_err++; $display("FAIL stream_gap: cycle %0d out_valid %b expected 1", cyc, a_ovalid); end
      end
      if (a_ovalid === 1'b1) begin
        if (first < 0) first = cyc;
        e = exp_a.pop_front();
        n_cmp++; if (a_opc !== e) begin n_err++; $display("FAIL stream_pc: got %h expected %h", a_opc, e); end
        n_cmp++; if (a_oinstr !== e[31:0]) begin n_err++; $display("FAIL stream_instr: got %h expected %h", a_oinstr, e[31:0]); end
      end
    end
    n_cmp++; if (first != 2) begin n_err++; $display("FAIL stream_latency: got %0d expected 2", first); end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL stream_timeout: %0d left expected 0", exp_a.size()); end
    exp_a.delete();
  endtask

  // Scenario 2: back-pressure saturates the queue, then drains without gaps.
  task automatic test_back_pressure;
    logic [63:0] e;
    reset_a(1'b0);
    for (int k = 0; k < 20 && a_occ !== 3'd4; k++) begin @(negedge clk); #1; end
    repeat (2) begin @(negedge clk); #1; end
    n_cmp++; if (a_occ !== 3'd4) begin n_err++; $display("FAIL bp_occ: got %0d expected 4", a_occ); end
    n_cmp++; if (a_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b expected 0", a_rd_en); end
    n_cmp++; if (a_fpc !== 64'h10) begin n_err++; $display("FAIL bp_fetch_pc: got %h expected 10", a_fpc); end
    for (int i = 0; i < 8; i++) exp_a.push_back(64'(i * 4));
    for (int k = 0; k < 40 && exp_a.size() != 0; k++) begin
      @(negedge clk); a_oready = 1'b1; #1;
      n_cmp++;
      if (a_ovalid !== 1'b1) begin
        n_err++; $display("FAIL bp_gap: out_valid %b expected 1", a_ovalid);
      end else begin
        e = exp_a.pop_front();
        if (a_opc !== e) begin n_err++; $display("FAIL bp_pc: got %h expected %h", a_opc, e); end
      end
    end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL bp_timeout: %0d left expected 0", exp_a.size()); end
    exp_a.delete();
  endtask

  // Scenario 3: redirect with 3 queued + 1 in flight, then unaligned target.
  task automatic test_redirect;
    logic [63:0] e;
    reset_a(1'b0);
    for (int k = 0; k < 20 && a_occ !== 3'd3; k++) begin @(negedge clk); #1; end
    n_cmp++; if (a_occ !== 3'd3 || a_rd_en !== 1'b0) begin n_err++; $display("FAIL redir_setup: occ %0d rd_en %b expected 3 0", a_occ, a_rd_en); end
    @(negedge clk); a_redir = 1'b1; a_redir_pc = 64'h100; a_oready = 1'b1; #1;
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b expected 0", a_ovalid); end
    @(negedge clk); a_redir = 1'b0; #1;
    n_cmp++; if (a_fpc !== 64'h100) begin n_err++; $display("FAIL redir_fetch_pc: got %h expected 100", a_fpc); end
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL redir_occ: got %0d expected 0", a_occ); end
    exp_a.push_back(64'h100); exp_a.push_back(64'h104); exp_a.push_back(64'h108);
    for (int k = 0; k < 40 && exp_a.size() != 0; k++) begin
      if (k != 0) begin @(negedge clk); #1; end
      if (a_ovalid === 1'b1) begin
        e = exp_a.pop_front();
        n_cmp++; if (a_opc !== e) begin n_err++; $display("FAIL redir_pc: got %h expected %h", a_opc, e); end
      end
    end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL redir_timeout: %0d left expected 0", exp_a.size()); end
    exp_a.delete();
    @(negedge clk); a_redir = 1'b1; a_redir_pc = 64'h102; #1;
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL redir2_valid: got %b expected 0", a_ovalid); end
    @(negedge clk); a_redir = 1'b0; #1;
    n_cmp++; if (a_fpc !== 64'h100) begin n_err++; $display("FAIL redir2_fetch_pc: got %h expected 100", a_fpc); end
    exp_a.push_back(64'h100); exp_a.push_back(64'h104);
    for (int k = 0; k < 40 && exp_a.size() != 0; k++) begin
      if (k != 0) begin @(negedge clk); #1; end
      if (a_ovalid === 1'b1) begin
        e = exp_a.pop_front();
        n_cmp++; if (a_opc !== e) begin n_err++; $display("FAIL redir2_pc: got %h expected %h", a_opc, e); end
      end
    end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL redir2_timeout: %0d left expected 0", exp_a.size()); end
    exp_a.delete();
  endtask

  // Scenario 4: redirect and out_ready in the same cycle with two entries queued.
  task automatic test_redirect_vs_pop;
    logic [63:0] e;
    reset_a(1'b0);
    for (int k = 0; k < 20 && a_occ !== 3'd2; k++) begin @(negedge clk); #1; end
    n_cmp++; if (a_occ !== 3'd2) begin n_err++; $display("FAIL rvp_setup: occ %0d expected 2", a_occ); end
    @(negedge clk); a_redir = 1'b1; a_redir_pc = 64'h200; a_oready = 1'b1; #1;
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL rvp_valid: got %b expected 0", a_ovalid); end
    @(negedge clk); a_redir = 1'b0; a_oready = 1'b0; #1;
    n_cmp++; if (a_occ !== 3'd0) begin n_err++; $display("FAIL rvp_occ: got %0d expected 0", a_occ); end
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL rvp_valid_next: got %b expected 0", a_ovalid); end
    exp_a.push_back(64'h200); exp_a.push_back(64'h204); exp_a.push_back(64'h208);
    for (int k = 0; k < 40 && exp_a.size() != 0; k++) begin
      @(negedge clk); a_oready = 1'b1; #1;
      if (a_ovalid === 1'b1) begin
        e = exp_a.pop_front();
        n_cmp++; if (a_opc !== e) begin n_err++; $display("FAIL rvp_pc: got %h expected %h", a_opc, e); end
      end
    end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL rvp_timeout: %0d left expected 0", exp_a.size()); end
    exp_a.delete();
  endtask

  // Scenario 5: PC wraps through zero from a high RESET_PC (MEM_LAT=3).
  task automatic test_pc_wrap;
    int first;
    logic [63:0] e;
    reset_b(1'b1);
    n_cmp++; if (b_fpc !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_err++; $display("FAIL wrap_reset_pc: got %h expected fff8", b_fpc); end
    exp_b.push_back(64'hFFFF_FFFF_FFFF_FFF8); exp_b.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_b.push_back(64'h0); exp_b.push_back(64'h4); exp_b.push_back(64'h8);
    first = -1;
    for (int cyc = 0; cyc < 60 && exp_b.size() != 0; cyc++) begin
      if (cyc != 0) begin @(negedge clk); #1; end
      if (b_ovalid === 1'b1) begin
        if (first < 0) first = cyc;
        e = exp_b.pop_front();
        n_cmp++; if (b_opc !== e) begin n_err++; $display("FAIL wrap_pc: got %h expected %h", b_opc, e); end
        n_cmp++; if (b_oinstr !== e[31:0]) begin n_err++; $display("FAIL wrap_instr: got %h expected %h", b_oinstr, e[31:0]); end
      end
    end
    n_cmp++; if (first != 4) begin n_err++; $display("FAIL wrap_latency: got %0d expected 4", first); end
    n_cmp++; if (exp_b.size() != 0) begin n_err++; $display("FAIL wrap_timeout: %0d left expected 0", exp_b.size()); end
    exp_b.delete();
  endtask

  // Scenario 6: reset pulse with two reads in flight; stale returns must vanish.
  task automatic test_reset_inflight;
    int first;
    logic [63:0] e;
    reset_b(1'b1);
    @(negedge clk); #1;
    n_cmp++; if (b_rd_en !== 1'b1) begin n_err++; $display("FAIL rif_second_req: got %b expected 1", b_rd_en); end
    @(negedge clk); b_rst = 1'b1; #1;
    n_cmp++; if (b_rd_en !== 1'b0 || b_ovalid !== 1'b0) begin n_err++; $display("FAIL rif_in_reset: rd_en %b out_valid %b expected 0 0", b_rd_en, b_ovalid); end
    @(negedge clk); b_rst = 1'b0; #1;
    n_cmp++; if (b_occ !== 3'd0) begin n_err++; $display("FAIL rif_occ: got %0d expected 0", b_occ); end
    exp_b.push_back(64'hFFFF_FFFF_FFFF_FFF8); exp_b.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_b.push_back(64'h0); exp_b.push_back(64'h4);
    first = -1;
    for (int cyc = 0; cyc < 60 && exp_b.size() != 0; cyc++) begin
      if (cyc != 0) begin @(negedge clk); #1; end
      if (b_ovalid === 1'b1) begin
        if (first < 0) first = cyc;
        e = exp_b.pop_front();
        n_cmp++; if (b_opc !== e) begin n_err++; $display("FAIL rif_pc: got %h expected %h", b_opc, e); end
      end
    end
    n_cmp++; if (first != 4) begin n_err++; $display("FAIL rif_latency: got %0d expected 4", first); end
    n_cmp++; if (exp_b.size() != 0) begin n_err++; $display("FAIL rif_timeout: %0d left expected 0", exp_b.size()); end
    exp_b.delete();
  endtask

  initial begin
    test_reset;
    test_stream;
    test_back_pressure;
    test_redirect;
    test_redirect_vs_pop;
    test_pc_wrap;
    test_reset_inflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
